instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL use one clock and a synchronous, active-low reset: clk input 1 (all state updates on the rising edge); rst_n input 1 (synchronous, active-low reset).
REQ-003 SHALL have the instruction memory ports: ImemReq output 1 (request valid); ImemGnt input 1 (memory accepts the request); ImemAddr output 32 (word-aligned fetch address); ImemRvalid input 1 (response valid); ImemRdata input 32 (fetched instruction).
REQ-004 SHALL have the control ports: Stall input 1 (decode holds its current instruction); PCSrc input 1 (branch/jump redirect); PCTarget input 32 (redirect address).
REQ-005 SHALL have the decode-side ports: InstrD output 32 (registered instruction); ImmD output 25 (InstrD[31:7], the immediate field consumed by the immediate generator); InstrValidD output 1 (InstrD valid); PCD output 32 (address of InstrD); PCPlus4D output 32 (PCD+4).

Function
REQ-006 SHALL implement the FSM states BOOT, ISSUE, WAIT, HOLD and DROP, with at most one memory request outstanding.
REQ-007 SHALL leave BOOT for ISSUE one cycle after rst_n deasserts, with ImemReq=0 while in BOOT.
REQ-008 In ISSUE, SHALL drive ImemReq=1 with ImemAddr=PC, moving to WAIT when ImemGnt=1 and otherwise holding ImemReq and ImemAddr stable.
REQ-009 In WAIT, on ImemRvalid with (Stall=0 or InstrValidD=0), SHALL load InstrD<=ImemRdata, PCD<=PC, PCPlus4D<=PC+4 and InstrValidD<=1, set PC<=PC+4, and return to ISSUE; the load is visible one cycle after ImemRvalid.
REQ-010 In WAIT, on ImemRvalid with Stall=1 and InstrValidD=1, SHALL capture the response into a 1-entry skid register and move to HOLD.
REQ-011 In HOLD, SHALL drive ImemReq=0, and on the first cycle with Stall=0 SHALL move the skid contents into the decode register per REQ-009 and return to ISSUE.
REQ-012 While Stall=1, SHALL hold InstrD, ImmD, PCD, PCPlus4D and InstrValidD unchanged.
REQ-013 ImmD SHALL always equal InstrD[31:7] combinationally.
REQ-014 PCSrc=1 SHALL take priority over Stall and all other events: PC<=PCTarget, InstrValidD<=0 next cycle, skid contents discarded.
REQ-015 A PCSrc=1 in WAIT without same-cycle ImemRvalid SHALL move to DROP; in DROP, the next ImemRvalid SHALL be discarded and the FSM SHALL move to ISSUE.
REQ-016 A PCSrc=1 in WAIT coincident with ImemRvalid SHALL discard that response and move to ISSUE.
REQ-017 A PCSrc=1 in ISSUE, HOLD or BOOT SHALL move to ISSUE with ImemAddr=PCTarget on the next cycle, ignoring any ImemGnt in the redirect cycle (the request is treated as not accepted).
REQ-018 All PC arithmetic SHALL be 32-bit modulo 2^32, so that 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.

Reset
REQ-019 While rst_n=0 at a clock edge, SHALL set state=BOOT, PC=RESET_PC, ImemReq=0, ImemAddr=RESET_PC, InstrD=32'h0000_0013 (NOP), ImmD=25'h0, InstrValidD=0, PCD=RESET_PC, PCPlus4D=RESET_PC+4, and the skid register empty.
REQ-020 Reset asserted mid-operation, including in WAIT or DROP, SHALL abandon the outstanding request, and the first ImemRvalid arriving after reset before a new grant SHALL be ignored.

Configuration
REQ-021 With FETCH_MISALIGN_CHECK_EN defined, SHALL add output MisalignErr 1, reset 0, set one cycle after PCSrc=1 with PCTarget[1:0]!=0 and held until reset; the misaligned redirect SHALL be ignored (PC unchanged) apart from flushing InstrValidD.
REQ-022 Without FETCH_MISALIGN_CHECK_EN, the MisalignErr port SHALL NOT exist, and PCTarget SHALL be used with bits [1:0] forced to 0.

Verification
REQ-023 Reset then ImemGnt=1 always, with a 1-cycle response of 32'hFFF00093 at address 0 -> ImemAddr=0, InstrD=32'hFFF00093, ImmD=25'h1FFE001, PCD=0, PCPlus4D=4, next ImemAddr=4.
REQ-024 ImemGnt=0 for 3 cycles in ISSUE -> ImemReq=1 and ImemAddr=8 held stable, no PC advance.
REQ-025 Stall=1 with InstrValidD=1 when the response 32'h00A00113 arrives -> FSM in HOLD, decode outputs unchanged; Stall=0 -> InstrD=32'h00A00113 one cycle later.
REQ-026 PCSrc=1 with PCTarget=32'h100 while in WAIT -> late response dropped, InstrValidD=0, next ImemAddr=32'h100.
REQ-027 RESET_PC=32'hFFFF_FFFC, one fetch -> PCPlus4D=0, next ImemAddr=0; rst_n=0 in WAIT -> all outputs at reset values one cycle later.
REQ-028 With FETCH_MISALIGN_CHECK_EN, PCTarget=32'h102 -> MisalignErr=1 and PC unchanged; without the macro -> next ImemAddr=32'h100.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction memory channel between the fetch stage (master) and instruction memory (slave).
// Request/grant handshake for the address, then a single-beat valid/data response.
interface instruction_fetch_if;
    logic        ImemReq;
    logic        ImemGnt;
    logic [31:0] ImemAddr;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemGnt,
        input  ImemRvalid,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemGnt,
        output ImemRvalid,
        output ImemRdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory request, 1-entry skid buffer for decode stalls.
// Build macro FETCH_MISALIGN_CHECK_EN adds MisalignErr and rejects misaligned redirect targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master imem,
    input  logic                Stall,
    input  logic                PCSrc,
    input  logic [31:0]         PCTarget,
    output logic [31:0]         InstrD,
    output logic [24:0]         ImmD,
    output logic                InstrValidD,
    output logic [31:0]         PCD,
    output logic [31:0]         PCPlus4D
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                MisalignErr
`endif
);

    typedef enum logic [2:0] {BOOT, ISSUE, WAIT, HOLD, DROP} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] skid_data;
    logic [31:0] load_data;
    logic [31:0] redirect_pc;
    logic        load;
    logic        capture;

    // A misaligned target keeps the current PC, so the redirect only flushes decode.
`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned  = (PCTarget[1:0] != 2'b00);
    assign redirect_pc = misaligned ? pc : PCTarget;
`else
    assign redirect_pc = PCTarget & 32'hFFFF_FFFC;
`endif

    assign imem.ImemReq  = (state == ISSUE);
    assign imem.ImemAddr = pc;
    assign ImmD          = InstrD[31:7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        capture    = 1'b0;
        load_data  = imem.ImemRdata;
        case (state)
            BOOT:  next_state = ISSUE;
            ISSUE: begin
                if (imem.ImemGnt) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem.ImemRvalid) begin
                    if (Stall && InstrValidD) begin
                        capture    = 1'b1;
                        next_state = HOLD;
                    end else begin
                        load       = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            HOLD: begin
                if (!Stall) begin
                    load       = 1'b1;
                    load_data  = skid_data;
                    next_state = ISSUE;
                end
            end
            DROP: begin
                if (imem.ImemRvalid) begin
                    next_state = ISSUE;
                end
            end
            default: next_state = BOOT;
        endcase
        // A redirect overrides everything; an un-returned request must still be drained.
        if (PCSrc) begin
            load    = 1'b0;
            capture = 1'b0;
            if (state == WAIT && !imem.ImemRvalid) begin
                next_state = DROP;
            end else if (state != DROP) begin
                next_state = ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            skid_data   <= 32'h0000_0000;
            InstrD      <= 32'h0000_0013;
            InstrValidD <= 1'b0;
            PCD         <= RESET_PC;
            PCPlus4D    <= RESET_PC + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
            MisalignErr <= 1'b0;
`endif
        end else begin
            if (PCSrc) begin
                pc          <= redirect_pc;
                InstrValidD <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (misaligned) begin
                    MisalignErr <= 1'b1;
                end
`endif
            end else if (load) begin
                pc          <= pc + 32'd4;
                InstrD      <= load_data;
                PCD         <= pc;
                PCPlus4D    <= pc + 32'd4;
                InstrValidD <= 1'b1;
            end
            if (capture) begin
                skid_data <= imem.ImemRdata;
            end
        end
    end

endmodule
